// File: rtl/btb_update_sched_if.sv
// Bundles the EX update inputs, flush/hold controls and BTB write-port outputs.
interface btb_update_sched_if #(
    parameter int unsigned SET_ADDR_LEN = 12,
    parameter int unsigned CNT_W        = 16
);
    logic                    upd_valid;
    logic [31:0]             upd_pc;
    logic [31:0]             upd_target;
    logic                    upd_br;
    logic                    flush_req;
    logic                    wr_hold;

    logic                    btb_wr_en;
    logic                    btb_wr_clr;
    logic [SET_ADDR_LEN-1:0] btb_wr_idx;
    logic [31:0]             btb_wr_pc;
    logic [31:0]             btb_wr_target;
    logic                    btb_wr_br;
    logic                    init_done;
    logic                    fifo_full;
    logic [CNT_W-1:0]        drop_cnt;

    modport master (
        output upd_valid, upd_pc, upd_target, upd_br, flush_req, wr_hold,
        input  btb_wr_en, btb_wr_clr, btb_wr_idx, btb_wr_pc, btb_wr_target,
               btb_wr_br, init_done, fifo_full, drop_cnt
    );

    modport slave (
        input  upd_valid, upd_pc, upd_target, upd_br, flush_req, wr_hold,
        output btb_wr_en, btb_wr_clr, btb_wr_idx, btb_wr_pc, btb_wr_target,
               btb_wr_br, init_done, fifo_full, drop_cnt
    );
endinterface

// File: rtl/btb_update_sched.sv
// BTB write-port scheduler: invalidation sweep after reset/flush, then drains
// queued EX branch updates in arrival order. Overflowing updates are counted.
module btb_update_sched #(
    parameter int unsigned SET_ADDR_LEN = 12,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CNT_W        = 16
) (
    input logic               clk,
    input logic               rst,
    btb_update_sched_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        br;
    } upd_t;

    state_e                  state_q, state_d;
    logic [SET_ADDR_LEN-1:0] clr_idx_q, clr_idx_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic [CNT_W-1:0]        drop_q, drop_d;
    upd_t                    fifo_q [FIFO_DEPTH];
    upd_t                    head;
    logic                    push, pop, empty, full;

    logic                    wr_en_q, wr_en_d;
    logic                    wr_clr_q, wr_clr_d;
    logic [SET_ADDR_LEN-1:0] wr_idx_q, wr_idx_d;
    logic [31:0]             wr_pc_q, wr_pc_d;
    logic [31:0]             wr_tgt_q, wr_tgt_d;
    logic                    wr_br_q, wr_br_d;
    logic                    init_done_q;
    logic                    fifo_full_q;

    // Next-state, queue control and write-port selection.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        occ_d     = occ_q;
        drop_d    = drop_q;
        wr_en_d   = 1'b0;
        wr_clr_d  = 1'b0;
        wr_idx_d  = '0;
        wr_pc_d   = '0;
        wr_tgt_d  = '0;
        wr_br_d   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        head      = fifo_q[rd_ptr_q];
        empty     = (occ_q == '0);
        full      = (occ_q == OCC_W'(FIFO_DEPTH));

        case (state_q)
            ST_CLEAR: begin
                if (!bus.wr_hold) begin
                    wr_en_d   = 1'b1;
                    wr_clr_d  = 1'b1;
                    wr_idx_d  = clr_idx_q;
                    clr_idx_d = clr_idx_q + SET_ADDR_LEN'(1);
                    if (clr_idx_q == '1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                pop = !empty && !bus.wr_hold;
                if (pop) begin
                    wr_en_d  = 1'b1;
                    wr_idx_d = head.pc[SET_ADDR_LEN+1:2];
                    wr_pc_d  = head.pc;
                    wr_tgt_d = head.target;
                    wr_br_d  = head.br;
                end
                // A pop in the same cycle frees the slot for the incoming update.
                if (bus.upd_valid && !bus.flush_req) begin
                    if (!full || pop) begin
                        push = 1'b1;
                    end else if (drop_q != '1) begin
                        drop_d = drop_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

        // Flush restarts the sweep and empties the queue; the write chosen above still goes out.
        if (bus.flush_req) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            occ_d     = '0;
        end
    end

    // State, pointers, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
            drop_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_clr_q    <= 1'b0;
            wr_idx_q    <= '0;
            wr_pc_q     <= '0;
            wr_tgt_q    <= '0;
            wr_br_q     <= 1'b0;
            init_done_q <= 1'b0;
            fifo_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            drop_q      <= drop_d;
            wr_en_q     <= wr_en_d;
            wr_clr_q    <= wr_clr_d;
            wr_idx_q    <= wr_idx_d;
            wr_pc_q     <= wr_pc_d;
            wr_tgt_q    <= wr_tgt_d;
            wr_br_q     <= wr_br_d;
            init_done_q <= (state_d == ST_RUN);
            fifo_full_q <= (occ_d == OCC_W'(FIFO_DEPTH));
        end
    end

    // Queue storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: bus.upd_pc, target: bus.upd_target, br: bus.upd_br};
        end
    end

    assign bus.btb_wr_en     = wr_en_q;
    assign bus.btb_wr_clr    = wr_clr_q;
    assign bus.btb_wr_idx    = wr_idx_q;
    assign bus.btb_wr_pc     = wr_pc_q;
    assign bus.btb_wr_target = wr_tgt_q;
    assign bus.btb_wr_br     = wr_br_q;
    assign bus.init_done     = init_done_q;
    assign bus.fifo_full     = fifo_full_q;
    assign bus.drop_cnt      = drop_q;
endmodule

// File: tb/tb_btb_update_sched.sv
// Directed bench for btb_update_sched with SET_ADDR_LEN=3, FIFO_DEPTH=4.
module tb_btb_update_sched;
    localparam int unsigned SAL   = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    btb_update_sched_if #(.SET_ADDR_LEN(SAL), .CNT_W(CW)) bus ();

    btb_update_sched #(.SET_ADDR_LEN(SAL), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic           hold;
        logic           valid;
        logic           flush;
        logic [31:0]    pc;
        logic [31:0]    tgt;
        logic           br;
        logic           e_en;
        logic           e_clr;
        logic [SAL-1:0] e_idx;
        logic [31:0]    e_pc;
        logic [31:0]    e_tgt;
        logic           e_br;
        logic           e_full;
        logic           e_init;
        logic [CW-1:0]  e_drop;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic hold, input logic valid, input logic flush,
                                input logic [31:0] pc, input logic [31:0] tgt, input logic br,
                                input logic e_en, input logic e_clr, input logic [SAL-1:0] e_idx,
                                input logic [31:0] e_pc, input logic [31:0] e_tgt, input logic e_br,
                                input logic e_full, input logic e_init, input logic [CW-1:0] e_drop);
        vec_t v;
        v.hold = hold; v.valid = valid; v.flush = flush;
        v.pc = pc; v.tgt = tgt; v.br = br;
        v.e_en = e_en; v.e_clr = e_clr; v.e_idx = e_idx;
        v.e_pc = e_pc; v.e_tgt = e_tgt; v.e_br = e_br;
        v.e_full = e_full; v.e_init = e_init; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, then compare every output.
    task automatic step(input string tag, input vec_t v);
        bus.wr_hold    = v.hold;
        bus.upd_valid  = v.valid;
        bus.flush_req  = v.flush;
        bus.upd_pc     = v.pc;
        bus.upd_target = v.tgt;
        bus.upd_br     = v.br;
        @(posedge clk);
        #1;
        chk({tag, ".wr_en"},  32'(bus.btb_wr_en),     32'(v.e_en));
        chk({tag, ".wr_clr"}, 32'(bus.btb_wr_clr),    32'(v.e_clr));
        chk({tag, ".wr_idx"}, 32'(bus.btb_wr_idx),    32'(v.e_idx));
        chk({tag, ".wr_pc"},  bus.btb_wr_pc,          v.e_pc);
        chk({tag, ".wr_tgt"}, bus.btb_wr_target,      v.e_tgt);
        chk({tag, ".wr_br"},  32'(bus.btb_wr_br),     32'(v.e_br));
        chk({tag, ".full"},   32'(bus.fifo_full),     32'(v.e_full));
        chk({tag, ".init"},   32'(bus.init_done),     32'(v.e_init));
        chk({tag, ".drop"},   32'(bus.drop_cnt),      32'(v.e_drop));
    endtask

    initial begin
        //                hold valid flush pc            tgt           br  en clr idx pc            tgt           br  full init drop
        tbl[0]  = mk(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 16'd0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 3'd4, 32'h0000_0010, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 16'd0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 16'd0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_1004, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 16'd0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 32'h0000_0108, 32'h0000_1008, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 16'd0);
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0000_010C, 32'h0000_100C, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 16'd0);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 32'h0000_0110, 32'h0000_1010, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 16'd1);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, 32'h0000_0114, 32'h0000_1014, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1, 16'd2);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0000_0118, 32'h0000_1018, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0100, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 16'd2);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_0104, 32'h0000_1004, 1'b1, 1'b0, 1'b1, 16'd2);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 3'd2, 32'h0000_0108, 32'h0000_1008, 1'b0, 1'b0, 1'b1, 16'd2);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 3'd3, 32'h0000_010C, 32'h0000_100C, 1'b1, 1'b0, 1'b1, 16'd2);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 3'd6, 32'h0000_0118, 32'h0000_1018, 1'b1, 1'b0, 1'b1, 16'd2);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 16'd2);
        tbl[14] = mk(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 16'd2);
        tbl[15] = mk(1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h0000_2004, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 16'd2);
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 32'h0000_0208, 32'h0000_2008, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 16'd2);
        tbl[17] = mk(1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_3000, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0200, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 16'd2);

        rst            = 1'b1;
        bus.wr_hold    = 1'b0;
        bus.upd_valid  = 1'b0;
        bus.flush_req  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_target = '0;
        bus.upd_br     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.wr_en", 32'(bus.btb_wr_en), 32'd0);
        chk("reset.init",  32'(bus.init_done), 32'd0);
        chk("reset.full",  32'(bus.fifo_full), 32'd0);
        chk("reset.drop",  32'(bus.drop_cnt),  32'd0);
        rst = 1'b0;

        // Sweep after reset, no hold: clears 0..7, RUN entered with the last clear.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("sweep%0d", i),
                 mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
                    1'b1, 1'b1, SAL'(i), 32'h0, 32'h0, 1'b0, 1'b0, (i == 7), 16'd0));
        end

        // Single update, overflow with drops, push+pop on full, then flush with 3 queued.
        for (int i = 0; i < 18; i++) begin
            step($sformatf("row%0d", i), tbl[i]);
        end

        // Sweep after flush with a 2-cycle hold at idx 3; updates during CLEAR are discarded uncounted.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("fsweep%0d", i),
                 mk(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_4000, 1'b1,
                    1'b1, 1'b1, SAL'(i), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd2));
        end
        for (int i = 0; i < 2; i++) begin
            step($sformatf("fhold%0d", i),
                 mk(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_4000, 1'b1,
                    1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd2));
        end
        for (int i = 3; i < 8; i++) begin
            step($sformatf("fsweep%0d", i),
                 mk(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_4000, 1'b1,
                    1'b1, 1'b1, SAL'(i), 32'h0, 32'h0, 1'b0, 1'b0, (i == 7), 16'd2));
        end

        // Queue must be empty after the sweep, then a fresh update drains normally.
        step("post_idle", mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
                             1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd2));
        step("post_push", mk(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0080, 1'b1,
                             1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd2));
        step("post_wr",   mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
                             1'b1, 1'b0, 3'd0, 32'h0000_0020, 32'h0000_0080, 1'b1, 1'b0, 1'b1, 16'd2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
